// File: rtl/boreal_duty_ramp.sv
// boreal_duty_ramp: clamps handshaked duty commands and slews the PWM duty once per frame.
// Optional command watchdog is built in when BOREAL_CMD_WATCHDOG_EN is defined.
module boreal_duty_ramp #(
  parameter int PERIOD   = 4096,
  parameter int STEP_MAX = 16,
  parameter int DUTY_MIN = 0,
  parameter int DUTY_MAX = 4095,
  parameter int WDOG_FRM = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        cmd_valid,
  input  logic [11:0] cmd_target,
  output logic        cmd_ready,
  output logic [11:0] duty_cycle,
  output logic        frame_strobe,
  output logic        at_target,
  output logic        fault
);

  localparam int          CW     = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [11:0] DMIN   = 12'(DUTY_MIN);
  localparam logic [11:0] DMAX   = 12'(DUTY_MAX);
  localparam logic [11:0] STEP12 = 12'(STEP_MAX);
  localparam logic [12:0] STEP13 = 13'(STEP_MAX);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RAMP = 2'd1,
    SAFE = 2'd2
  } state_t;

  function automatic logic [11:0] clamp_duty(input logic [11:0] v);
    if (v < DMIN) begin
      return DMIN;
    end else if (v > DMAX) begin
      return DMAX;
    end else begin
      return v;
    end
  endfunction

  logic [CW-1:0]       cnt_r;
  logic [11:0]         pend_r;
  logic [11:0]         active_r;
  state_t              state_r;
  logic                xfer_s;
  logic                trip_s;
  logic                lands_s;
  logic [11:0]         clamp_s;
  logic [11:0]         next_active_s;
  logic [11:0]         eff_s;
  logic signed [12:0]  diff_s;
  logic [12:0]         mag_s;
  logic [11:0]         duty_next_s;

  // Frame counter; the strobe is high for the last count so the duty edge lands on the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r        <= '0;
      frame_strobe <= 1'b0;
    end else begin
      cnt_r        <= (cnt_r == LAST) ? '0 : cnt_r + CW'(1);
      frame_strobe <= (cnt_r == LAST - CW'(1));
    end
  end

  // Next active target, effective target and one slew step toward it.
  always_comb begin
    xfer_s        = cmd_valid & cmd_ready;
    clamp_s       = clamp_duty(cmd_target);
    next_active_s = active_r;
    eff_s         = 12'd0;
    diff_s        = 13'sd0;
    mag_s         = 13'd0;
    duty_next_s   = duty_cycle;
    lands_s       = 1'b0;
    // A command arriving on the frame edge bypasses the slot; otherwise the slot drains.
    if (xfer_s) begin
      next_active_s = clamp_s;
    end else if (!cmd_ready) begin
      next_active_s = pend_r;
    end else begin
      next_active_s = active_r;
    end
    if (enable && !(state_r == SAFE && !xfer_s)) begin
      eff_s = next_active_s;
    end else begin
      eff_s = 12'd0;
    end
    diff_s = $signed({1'b0, eff_s}) - $signed({1'b0, duty_cycle});
    if (diff_s[12]) begin
      mag_s = 13'(-diff_s);
    end else begin
      mag_s = 13'(diff_s);
    end
    if (mag_s <= STEP13) begin
      duty_next_s = eff_s;
    end else if (diff_s[12]) begin
      duty_next_s = duty_cycle - STEP12;
    end else begin
      duty_next_s = duty_cycle + STEP12;
    end
    lands_s = (duty_next_s == eff_s);
  end

`ifdef BOREAL_CMD_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_FRM + 1);
  logic [WW-1:0] wd_r;

  // Frames elapsed since the last accepted command, saturating at the trip count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_r <= '0;
    end else if (xfer_s) begin
      wd_r <= '0;
    end else if (frame_strobe && (wd_r != WW'(WDOG_FRM))) begin
      wd_r <= wd_r + WW'(1);
    end else begin
      wd_r <= wd_r;
    end
  end

  assign trip_s = frame_strobe & ~xfer_s & (state_r != SAFE) & (wd_r == WW'(WDOG_FRM - 1));
`else
  assign trip_s = 1'b0;
`endif

  // Command slot, active target, duty slew and HOLD/RAMP/SAFE state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r     <= 12'd0;
      active_r   <= 12'd0;
      cmd_ready  <= 1'b1;
      duty_cycle <= 12'd0;
      state_r    <= HOLD;
      at_target  <= 1'b1;
      fault      <= 1'b0;
    end else if (frame_strobe) begin
      active_r   <= next_active_s;
      cmd_ready  <= 1'b1;
      duty_cycle <= duty_next_s;
      if (trip_s) begin
        state_r   <= SAFE;
        at_target <= 1'b0;
        fault     <= 1'b1;
      end else if (state_r == SAFE && !xfer_s) begin
        state_r   <= SAFE;
        at_target <= 1'b0;
      end else begin
        state_r   <= lands_s ? HOLD : RAMP;
        at_target <= lands_s;
        fault     <= 1'b0;
      end
    end else if (xfer_s) begin
      pend_r    <= clamp_s;
      cmd_ready <= 1'b0;
      if (state_r == SAFE) begin
        state_r   <= RAMP;
        at_target <= 1'b0;
        fault     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_boreal_duty_ramp.sv
// Randomized and directed bench for boreal_duty_ramp against a frame-level behavioural model.
module tb_boreal_duty_ramp;

  localparam int P     = 64;
  localparam int STEP  = 16;
  localparam int DMIN  = 0;
  localparam int DMAX  = 3000;
  localparam int WDOG  = 4;
`ifdef BOREAL_CMD_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [11:0] cmd_target = 12'd0;
  logic        cmd_ready;
  logic [11:0] duty_cycle;
  logic        frame_strobe;
  logic        at_target;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int m_pos, m_duty, m_active, m_idle;
  bit m_at, m_fault, m_edge, m_acc;
  int m_pend[$];

  boreal_duty_ramp #(
    .PERIOD(P), .STEP_MAX(STEP), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .WDOG_FRM(WDOG)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cmd_valid(cmd_valid), .cmd_target(cmd_target),
    .cmd_ready(cmd_ready), .duty_cycle(duty_cycle), .frame_strobe(frame_strobe),
    .at_target(at_target), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic model_reset();
    m_pos = 0; m_duty = 0; m_active = 0; m_idle = 0;
    m_at = 1'b1; m_fault = 1'b0; m_edge = 1'b0; m_acc = 1'b0;
    m_pend.delete();
  endtask

  // One clock: the model applies the frame rules to the inputs the DUT sees on this edge.
  task automatic tick();
    int cl, eff, d;
    bit acc;
    @(posedge clk);
    m_edge = 1'b0;
    m_acc  = 1'b0;
    if (!rst) begin
      acc = cmd_valid && (m_pend.size() == 0);
      cl  = (int'(cmd_target) < DMIN) ? DMIN : (int'(cmd_target) > DMAX) ? DMAX : int'(cmd_target);
      if (m_pos == P - 1) begin
        m_edge = 1'b1;
        if (acc) m_active = cl;
        else if (m_pend.size() != 0) m_active = m_pend.pop_front();
        eff = (enable && !(m_fault && !acc)) ? m_active : 0;
        d = eff - m_duty;
        if (d > STEP) m_duty = m_duty + STEP;
        else if (d < -STEP) m_duty = m_duty - STEP;
        else m_duty = eff;
        if (acc) begin
          m_idle = 0;
          m_fault = 1'b0;
        end else begin
          m_idle++;
        end
        if (WD_EN && !acc && !m_fault && m_idle >= WDOG) m_fault = 1'b1;
        m_at = !m_fault && (m_duty == eff);
      end else if (acc) begin
        m_pend.push_back(cl);
        m_idle = 0;
        if (m_fault) begin
          m_fault = 1'b0;
          m_at = 1'b0;
        end
      end
      m_pos = (m_pos + 1) % P;
      m_acc = acc;
    end
    #1;
  endtask

  task automatic wait_edge(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < P + 1; i++) begin
      tick();
      if (m_edge) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int first = -1;
    rst = 1'b1;
    model_reset();
    repeat (5) tick();
    rst = 1'b0;
    n_vec += 5;
    if (duty_cycle !== 12'd0) begin n_err++; $display("FAIL reset_duty got %0d want 0", duty_cycle); end
    if (at_target !== 1'b1) begin n_err++; $display("FAIL reset_at got %b want 1", at_target); end
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
    if (frame_strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe got %b want 0", frame_strobe); end
    if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b want 0", fault); end
    for (int c = 1; c <= P + 2; c++) begin
      tick();
      if (frame_strobe === 1'b1 && first < 0) first = c;
      n_vec++;
      if (frame_strobe !== (m_pos == P - 1)) begin
        n_err++; $display("FAIL strobe_phase cycle %0d got %b want %b", c, frame_strobe, m_pos == P - 1);
      end
    end
    n_vec++;
    if (first != P - 1) begin n_err++; $display("FAIL first_strobe got %0d want %0d", first, P - 1); end
  endtask

  task automatic test_ramp_up();
    int exp_r[7] = '{16, 32, 48, 64, 80, 96, 100};
    bit ok;
    enable = 1'b1;
    cmd_valid = 1'b1; cmd_target = 12'd100;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      wait_edge(ok);
      n_vec += 3;
      if (!ok) begin n_err++; $display("FAIL ramp_timeout frame %0d got none want edge", k); end
      if (duty_cycle !== 12'(exp_r[k])) begin
        n_err++; $display("FAIL ramp_duty frame %0d got %0d want %0d", k, duty_cycle, exp_r[k]);
      end
      if (at_target !== (k == 6)) begin
        n_err++; $display("FAIL ramp_at frame %0d got %b want %b", k, at_target, k == 6);
      end
    end
  endtask

  task automatic test_coincide_enable();
    int exp_d[4] = '{48, 32, 16, 0};
    bit ok;
    for (int i = 0; i < P && m_pos != P - 1; i++) tick();
    cmd_valid = 1'b1; cmd_target = 12'd50;
    tick();
    cmd_valid = 1'b0;
    n_vec += 3;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL coincide_ready got %b want 1", cmd_ready); end
    if (duty_cycle !== 12'd84) begin n_err++; $display("FAIL coincide_duty got %0d want 84", duty_cycle); end
    if (duty_cycle !== 12'(m_duty)) begin n_err++; $display("FAIL coincide_model got %0d want %0d", duty_cycle, m_duty); end
    repeat (3) wait_edge(ok);
    n_vec++;
    if (duty_cycle !== 12'd50) begin n_err++; $display("FAIL coincide_settle got %0d want 50", duty_cycle); end
    cmd_valid = 1'b1; cmd_target = 12'd64;
    tick();
    cmd_valid = 1'b0;
    wait_edge(ok);
    n_vec++;
    if (duty_cycle !== 12'd64) begin n_err++; $display("FAIL small_step got %0d want 64", duty_cycle); end
    enable = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_edge(ok);
      n_vec++;
      if (!ok || duty_cycle !== 12'(exp_d[k])) begin
        n_err++; $display("FAIL disable_ramp frame %0d got %0d want %0d", k, duty_cycle, exp_d[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    cmd_valid = 1'b1; cmd_target = 12'd200;
    tick();
    cmd_valid = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 6 && m_duty != 48; k++) wait_edge(ok);
    n_vec++;
    if (duty_cycle !== 12'd48) begin n_err++; $display("FAIL midrst_pre got %0d want 48", duty_cycle); end
    if (m_pos == P - 1) tick();
    cmd_valid = 1'b1; cmd_target = 12'd300;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    n_vec += 3;
    if (duty_cycle !== 12'd0) begin n_err++; $display("FAIL midrst_duty got %0d want 0", duty_cycle); end
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready got %b want 1", cmd_ready); end
    if (at_target !== 1'b1) begin n_err++; $display("FAIL midrst_at got %b want 1", at_target); end
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) wait_edge(ok);
    n_vec++;
    if (duty_cycle !== 12'd0) begin n_err++; $display("FAIL midrst_lost got %0d want 0", duty_cycle); end
  endtask

`ifdef BOREAL_CMD_WATCHDOG_EN
  task automatic test_watchdog();
    int exp_d[3] = '{24, 8, 0};
    bit ok;
    enable = 1'b1;
    if (m_pos == P - 1) tick();
    cmd_valid = 1'b1; cmd_target = 12'd40;
    tick();
    cmd_valid = 1'b0;
    for (int k = 0; k < 8 && !m_fault; k++) wait_edge(ok);
    n_vec += 2;
    if (fault !== 1'b1) begin n_err++; $display("FAIL wdog_trip got %b want 1", fault); end
    if (duty_cycle !== 12'd40) begin n_err++; $display("FAIL wdog_hold got %0d want 40", duty_cycle); end
    for (int k = 0; k < 3; k++) begin
      wait_edge(ok);
      n_vec++;
      if (duty_cycle !== 12'(exp_d[k])) begin
        n_err++; $display("FAIL wdog_down frame %0d got %0d want %0d", k, duty_cycle, exp_d[k]);
      end
    end
    if (m_pos == P - 1) tick();
    cmd_valid = 1'b1; cmd_target = 12'd40;
    tick();
    cmd_valid = 1'b0;
    n_vec++;
    if (fault !== 1'b0) begin n_err++; $display("FAIL wdog_clear got %b want 0", fault); end
  endtask
`endif

  task automatic test_clamp_backpressure();
    bit ok;
    int edge_c, acc_c, c;
    enable = 1'b1;
    cmd_valid = 1'b1; cmd_target = 12'd4000;
    for (int k = 0; k < 200 && !(m_at && m_duty == DMAX); k++) begin
      wait_edge(ok);
      n_vec++;
      if (duty_cycle !== 12'(m_duty)) begin n_err++; $display("FAIL clamp_track got %0d want %0d", duty_cycle, m_duty); end
    end
    n_vec += 2;
    if (duty_cycle !== 12'd3000) begin n_err++; $display("FAIL clamp_duty got %0d want 3000", duty_cycle); end
    if (at_target !== 1'b1) begin n_err++; $display("FAIL clamp_at got %b want 1", at_target); end
    // slot now holds the re-sent command; a new one must stall until the edge
    cmd_target = 12'd2990;
    edge_c = -1; acc_c = -1; c = 0;
    while (acc_c < 0 && c < 2 * P) begin
      tick();
      c++;
      if (m_edge) edge_c = c;
      if (m_acc && edge_c >= 0) acc_c = c;
      n_vec++;
      if (cmd_ready !== (m_pend.size() == 0)) begin
        n_err++; $display("FAIL bp_ready cycle %0d got %b want %b", c, cmd_ready, m_pend.size() == 0);
      end
    end
    cmd_valid = 1'b0;
    n_vec++;
    if (edge_c < 0 || acc_c != edge_c + 1) begin
      n_err++; $display("FAIL bp_accept got cycle %0d want %0d", acc_c, edge_c + 1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_target = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      tick();
      n_vec += 5;
      if (duty_cycle !== 12'(m_duty)) begin n_err++; $display("FAIL rnd_duty cycle %0d got %0d want %0d", c, duty_cycle, m_duty); end
      if (at_target !== m_at) begin n_err++; $display("FAIL rnd_at cycle %0d got %b want %b", c, at_target, m_at); end
      if (cmd_ready !== (m_pend.size() == 0)) begin n_err++; $display("FAIL rnd_ready cycle %0d got %b want %b", c, cmd_ready, m_pend.size() == 0); end
      if (frame_strobe !== (m_pos == P - 1)) begin n_err++; $display("FAIL rnd_strobe cycle %0d got %b want %b", c, frame_strobe, m_pos == P - 1); end
      if (fault !== m_fault) begin n_err++; $display("FAIL rnd_fault cycle %0d got %b want %b", c, fault, m_fault); end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_coincide_enable();
    test_mid_reset();
`ifdef BOREAL_CMD_WATCHDOG_EN
    test_watchdog();
`endif
    test_clamp_backpressure();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
